// File: rtl/inv_shift_rows_seq.sv
// Sequential AES InvShiftRows.
//
// Accepts one 128-bit state in IDLE and then rotates one row per cycle in SHIFT:
// row r is rotated right by r bytes, so output byte c is input byte (c - r) mod 4.
// Row 0 is rewritten unchanged. After the last row the block presents the result
// in DONE until the consumer accepts it.
//
// State layout: row r occupies bits [127-32r : 96-32r].
// Byte c of row r occupies bits [127-32r-8c : 120-32r-8c].
//
// Ports:
//   clk             rising-edge clock
//   n_rst           asynchronous active-low reset
//   clear           synchronous abort back to IDLE (data register holds)
//   in_valid        input_block is valid
//   in_ready        block can accept input (IDLE only)
//   input_block     AES state after ShiftRows
//   out_valid       unshifted_block is valid (DONE only)
//   out_ready       consumer accepts unshifted_block
//   unshifted_block AES state after InvShiftRows (always the data register)
//   busy            high while in SHIFT
module inv_shift_rows_seq #(
    parameter int unsigned NUM_ROWS = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] input_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] unshifted_block,
    output logic         busy
);

    localparam int unsigned ROW_W    = 32;
    localparam logic [1:0]  LAST_ROW = 2'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     row_cnt_q, row_cnt_d;
    logic [127:0]   data_q, data_d;

    // Rotate a 32-bit row right by amt bytes (MSB byte is byte 0).
    function automatic logic [31:0] rot_right_bytes(input logic [31:0] row,
                                                    input logic [1:0]  amt);
        logic [31:0] res;
        case (amt)
            2'd0:    res = row;
            2'd1:    res = {row[7:0],  row[31:8]};
            2'd2:    res = {row[15:0], row[31:16]};
            default: res = {row[23:0], row[31:24]};
        endcase
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        data_d    = data_q;

        if (clear) begin
            // Abort wins over everything, including a same-cycle load.
            state_d   = StIdle;
            row_cnt_d = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_d    = input_block;
                        row_cnt_d = 2'd0;
                        state_d   = StShift;
                    end
                end
                StShift: begin
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        if (row_cnt_q == 2'(r)) begin
                            data_d[127 - ROW_W * r -: ROW_W] =
                                rot_right_bytes(data_q[127 - ROW_W * r -: ROW_W], row_cnt_q);
                        end
                    end
                    // Wraps to 0 after the last row.
                    row_cnt_d = row_cnt_q + 2'd1;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            row_cnt_q <= 2'd0;
            data_q    <= 128'h0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            data_q    <= data_d;
        end
    end

    assign in_ready        = (state_q == StIdle);
    assign out_valid       = (state_q == StDone);
    assign busy            = (state_q == StShift);
    assign unshifted_block = data_q;

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
module tb_inv_shift_rows_seq;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] input_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] unshifted_block;
    logic         busy;

    int n_checks;
    int n_errors;

    inv_shift_rows_seq dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .input_block     (input_block),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .unshifted_block (unshifted_block),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward ShiftRows: out byte c of row r = in byte (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res[127 - 32 * r - 8 * c -: 8] = blk[127 - 32 * r - 8 * ((c + r) % 4) -: 8];
            end
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block for a single cycle and wait (bounded) for out_valid.
    task automatic send(input logic [127:0] blk, output int lat);
        in_valid    = 1'b1;
        input_block = blk;
        tick();
        lat      = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [127:0] rnd;
    logic [127:0] held;
    int           lat;
    int           accepts;
    int           seen_ov;
    logic         prev_ov;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        n_rst       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        input_block = 128'h0;

        // Reset state, during and after reset.
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_data", unshifted_block, 128'h0);
        n_rst = 1'b1;
        tick();
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        check("post_rst_out_valid", 128'(out_valid), 128'd0);

        // Known vector, with latency.
        send(128'hD55D4040_80AFE437_28F0ECBA_972B30F8, lat);
        check("kv_latency", 128'(lat), 128'd5);
        check("kv_out_valid", 128'(out_valid), 128'd1);
        check("kv_data", unshifted_block, 128'hD55D4040_3780AFE4_ECBA28F0_2B30F897);
        ack();
        check("kv_idle", 128'(in_ready), 128'd1);

        // Byte-index vector, checking out_valid is low one edge early.
        in_valid    = 1'b1;
        input_block = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        tick();
        in_valid = 1'b0;
        check("bi_busy", 128'(busy), 128'd1);
        check("bi_in_ready_shift", 128'(in_ready), 128'd0);
        repeat (3) tick();
        check("bi_not_yet_valid", 128'(out_valid), 128'd0);
        tick();
        check("bi_out_valid", 128'(out_valid), 128'd1);
        check("bi_data", unshifted_block, 128'h00010203_07040506_0A0B0809_0D0E0F0C);

        // Backpressure: hold 10 cycles, in_valid ignored in DONE.
        held     = unshifted_block;
        in_valid = 1'b1;
        input_block = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_data", unshifted_block, held);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        ack();
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);

        // out_ready during SHIFT has no effect.
        out_ready = 1'b1;
        send(128'h11223344_55667788_99AABBCC_DDEEFF00, lat);
        check("or_shift_latency", 128'(lat), 128'd5);
        check("or_shift_data", unshifted_block, 128'h11223344_88556677_BBCC99AA_EEFF00DD);
        tick();
        out_ready = 1'b0;
        check("or_shift_idle", 128'(in_ready), 128'd1);

        // Clear during the 2nd SHIFT cycle; data holds.
        in_valid    = 1'b1;
        input_block = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        tick();
        in_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", 128'(busy), 128'd0);
        check("clr_in_ready", 128'(in_ready), 128'd1);
        check("clr_data_hold", unshifted_block, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        seen_ov = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen_ov++;
        end
        check("clr_no_out_valid", 128'(seen_ov), 128'd0);

        // Clear with a same-cycle load drops the load.
        clear       = 1'b1;
        in_valid    = 1'b1;
        input_block = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_drop_busy", 128'(busy), 128'd0);
        check("clr_drop_data", unshifted_block, 128'h00010203_04050607_08090A0B_0C0D0E0F);

        // Fresh vector after clear.
        send(128'hD55D4040_80AFE437_28F0ECBA_972B30F8, lat);
        check("clr_fresh_latency", 128'(lat), 128'd5);
        check("clr_fresh_data", unshifted_block, 128'hD55D4040_3780AFE4_ECBA28F0_2B30F897);

        // Asynchronous reset mid-cycle while in DONE.
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_data", unshifted_block, 128'h0);
        check("arst_in_ready", 128'(in_ready), 128'd1);
        #2;
        n_rst = 1'b1;
        seen_ov = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen_ov++;
            check("arst_release_in_ready", 128'(in_ready), 128'd1);
        end
        check("arst_no_out_valid", 128'(seen_ov), 128'd0);

        // Back-to-back with in_valid and out_ready held high: 6-cycle period.
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        input_block = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        accepts     = 0;
        prev_ov     = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (in_ready) accepts++;
            tick();
            if (prev_ov) check("b2b_next_accept", 128'(in_ready), 128'd1);
            if (out_valid) begin
                check("b2b_data", unshifted_block, 128'h00010203_07040506_0A0B0809_0D0E0F0C);
            end
            prev_ov = out_valid;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", 128'(accepts), 128'd3);
        check("b2b_end_idle", 128'(in_ready), 128'd1);

        // Round trip against the forward ShiftRows.
        for (int i = 0; i < 50; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            send(shift_rows(rnd), lat);
            check("rt_latency", 128'(lat), 128'd5);
            check("rt_data", unshifted_block, rnd);
            ack();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inv_shift_rows_seq.md
INV_SHIFT_ROWS_SEQ -- requirements
Module: inv_shift_rows_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and n_rst.
REQ-002 The block SHALL provide the following ports:
- clk: input, 1 bit; rising-edge clock.
- n_rst: input, 1 bit; asynchronous active-low reset.
- clear: input, 1 bit; synchronous abort, returns the block to IDLE.
- in_valid: input, 1 bit; input_block is valid.
- in_ready: output, 1 bit; block can accept a new input_block.
- input_block: input, 128 bits; AES state after ShiftRows.
- out_valid: output, 1 bit; unshifted_block is valid.
- out_ready: input, 1 bit; consumer accepts unshifted_block.
- unshifted_block: output, 128 bits; AES state after InvShiftRows.
- busy: output, 1 bit; high while in state SHIFT.
REQ-003 Parameter NUM_ROWS SHALL default to 4 (rows per state) and SHALL NOT be overridden.

Function
REQ-004 State layout SHALL be: row r occupies bits [127-32r : 96-32r], and byte c of row r occupies bits [127-32r-8c : 120-32r-8c].
REQ-005 InvShiftRows SHALL rotate row r right by r bytes, so that out byte c equals in byte (c-r) mod 4. This is the exact inverse of the team's shift_rows, which rotates row r left by r bytes.
REQ-006 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-007 in_ready SHALL be 1 only in IDLE, and SHALL be decoded combinationally from the state.
REQ-008 When in IDLE and in_valid=1, the block SHALL load input_block into the internal data register, set row_cnt=0 and move to SHIFT on the next rising edge.
REQ-009 Each cycle in SHIFT, the block SHALL rotate row row_cnt of the data register per REQ-005, then increment row_cnt.
- Row 0 SHALL be rewritten unchanged.
- Rows other than row_cnt SHALL hold.
REQ-010 The block SHALL move from SHIFT to DONE on the edge at which row_cnt==3 is processed; row_cnt SHALL then wrap to 0.
REQ-011 out_valid SHALL be 1 only in DONE, and unshifted_block SHALL drive the data register at all times.
REQ-012 Latency: out_valid SHALL first go high exactly 5 rising edges after the acceptance edge (1 load edge + 4 row edges).
REQ-013 In DONE, the block SHALL hold unshifted_block and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-014 No new input SHALL be accepted in SHIFT or DONE, and in_valid SHALL be ignored in those states.
REQ-015 clear=1 SHALL force state=IDLE and row_cnt=0 on the next edge from any state, and SHALL take priority over every other input.
- The data register SHALL hold its value.
- A load requested in the same cycle SHALL be dropped.
REQ-016 out_ready while not in DONE SHALL have no effect.
REQ-017 busy SHALL equal (state==SHIFT).

Reset
REQ-018 With n_rst=0, the block SHALL immediately, independent of clk, set state=IDLE, row_cnt=0 and the data register to 128'h0.
REQ-019 During and after reset, outputs SHALL be out_valid=0, busy=0, in_ready=1 and unshifted_block=128'h0.
REQ-020 Reset asserted mid-SHIFT or mid-DONE SHALL abandon the operation, and no out_valid SHALL follow it.

Verification
REQ-021 Known vector:
- Stimulus: input_block=128'hD55D4040_80AFE437_28F0ECBA_972B30F8, in_valid for 1 cycle.
- Response: out_valid on edge 5; unshifted_block=128'hD55D4040_3780AFE4_EC BA28F0 (128'hD55D4040_3780AFE4_ECBA28F0_2B30F897).
REQ-022 Byte-index vector:
- Stimulus: input_block=128'h00010203_04050607_08090A0B_0C0D0E0F.
- Response: unshifted_block=128'h00010203_07040506_0A0B0809_0D0E0F0C.
REQ-023 Backpressure: hold out_ready=0 for 10 cycles after out_valid.
- out_valid and data SHALL stay stable and in_ready SHALL stay 0 during the hold.
- out_ready=1 SHALL give IDLE and in_ready=1 on the next edge.
REQ-024 clear: assert clear during the 2nd SHIFT cycle.
- The block SHALL be back in IDLE next edge with busy=0, in_ready=1 and out_valid never asserted.
- A fresh vector SHALL then process correctly.
REQ-025 Asynchronous reset: drop n_rst mid-cycle while in DONE.
- out_valid=0 and unshifted_block=0 SHALL take effect before the next clk edge.
- in_ready=1 SHALL hold after reset release.
REQ-026 Back-to-back and round-trip:
- Back-to-back: hold in_valid=1 continuously; exactly one acceptance per transaction, and the next accept occurs in the cycle after the out_ready handshake.
- Round trip: shift_rows followed by inv_shift_rows_seq SHALL return the original block for 50 random vectors.
